// File: rtl/accu_obf_pingpong_pkg.sv
// Shared definitions for the ping-pong accumulating output buffer:
// default widths, the address-width helper and the drain FSM states.
package accu_obf_pingpong_pkg;

    localparam int DEF_NB_ROWS      = 8;
    localparam int DEF_PE_OUT_WIDTH = 24;
    localparam int DEF_ACC_WIDTH    = 32;
    localparam int DEF_OUT_WIDTH    = 16;
    localparam int DEF_DEPTH        = 1024;

    // Bits needed to index 'value' entries (minimum 1).
    function automatic int clogb2(input int value);
        int v;
        int n;
        n = 0;
        for (v = value - 1; v > 0; v = v >> 1) n++;
        return (n == 0) ? 1 : n;
    endfunction

    typedef enum logic [1:0] {
        DRAIN_IDLE   = 2'd0,
        DRAIN_READ   = 2'd1,
        DRAIN_STREAM = 2'd2
    } drain_state_e;

endpackage

// File: rtl/obf_lane_quant.sv
// One lane of drain quantisation: round-half-up arithmetic right shift,
// then saturation to the signed output range.
module obf_lane_quant #(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   q
);

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] RND_ONE = {{ACC_WIDTH{1'b0}}, 1'b1};

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] r;

    // One guard bit above the accumulator so the rounding add cannot wrap.
    always_comb begin
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = (shift != '0) ? (RND_ONE << (shift - 1'b1)) : '0;
        sum = ext + rnd;
        r   = sum >>> shift;
        if (r > SAT_MAX) begin
            q = SAT_MAX[OUT_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            q = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            q = r[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/accu_obf_pingpong.sv
// Two-bank accumulating output buffer: the fill bank takes read-modify-write
// partial sums, the drain bank is quantised and streamed over valid/ready.
module accu_obf_pingpong
    import accu_obf_pingpong_pkg::*;
#(
    parameter int NB_ROWS      = DEF_NB_ROWS,
    parameter int PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_WIDTH   = clogb2(DEPTH),
    parameter int SHIFT_WIDTH  = clogb2(ACC_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            acc_valid,
    input  logic                            acc_first,
    input  logic [ADDR_WIDTH-1:0]           acc_addr,
    input  logic [NB_ROWS*PE_OUT_WIDTH-1:0] acc_data,
    input  logic                            swap_req,
    output logic                            swap_ack,
    input  logic                            drain_start,
    input  logic [ADDR_WIDTH:0]             drain_len,
    input  logic [SHIFT_WIDTH-1:0]          shift_amt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NB_ROWS*OUT_WIDTH-1:0]    out_data,
    output logic                            out_last,
    output logic                            drain_busy,
    output logic                            fill_bank
);

    localparam int ACC_BUS = NB_ROWS * ACC_WIDTH;

    // Handshake: a beat transfers on every rising edge where out_valid and
    // out_ready are both high; out_data/out_last hold while valid waits for ready.

    logic [ACC_BUS-1:0] mem [2*DEPTH];

    logic                            s1_valid;
    logic                            s1_first;
    logic [ADDR_WIDTH-1:0]           s1_addr;
    logic [NB_ROWS*PE_OUT_WIDTH-1:0] s1_data;
    logic [ACC_BUS-1:0]              s1_old;
    logic [ACC_BUS-1:0]              s1_res;

    drain_state_e           state;
    logic [ADDR_WIDTH:0]    cnt;
    logic [ADDR_WIDTH:0]    cnt_nxt;
    logic [ADDR_WIDTH:0]    len_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [ACC_BUS-1:0]     dr_q;
    logic                   swap_pend;
    logic                   swap_do;
    logic                   drain_go;
    logic                   fwd;

    assign fwd        = s1_valid && (s1_addr == acc_addr);
    assign drain_go   = (state == DRAIN_IDLE) && drain_start && (drain_len != '0);
    assign swap_do    = swap_pend && (state == DRAIN_IDLE) && !drain_go && !s1_valid && !acc_valid;
    assign cnt_nxt    = cnt + 1'b1;
    assign drain_busy = (state != DRAIN_IDLE);

    for (genvar g = 0; g < NB_ROWS; g++) begin : g_lane
        logic signed [PE_OUT_WIDTH-1:0] pe_in;
        logic signed [ACC_WIDTH-1:0]    pe_ext;

        assign pe_in  = s1_data[g*PE_OUT_WIDTH +: PE_OUT_WIDTH];
        assign pe_ext = ACC_WIDTH'(pe_in);
        assign s1_res[g*ACC_WIDTH +: ACC_WIDTH] =
            s1_first ? pe_ext : s1_old[g*ACC_WIDTH +: ACC_WIDTH] + pe_ext;

        obf_lane_quant #(
            .ACC_WIDTH  (ACC_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH)
        ) u_quant (
            .acc  (dr_q[g*ACC_WIDTH +: ACC_WIDTH]),
            .shift(shift_q),
            .q    (out_data[g*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // A back-to-back beat to the same entry takes the in-flight result, since
    // the memory write for that entry lands on the same edge as this read.
    always_ff @(posedge clk) begin
        if (acc_valid) begin
            s1_old <= fwd ? s1_res : mem[{fill_bank, acc_addr}];
        end
        if (s1_valid && !rst_n) begin
            mem[{fill_bank, s1_addr}] <= s1_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= acc_valid;
            if (acc_valid) begin
                s1_first <= acc_first;
                s1_addr  <= acc_addr;
                s1_data  <= acc_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fill_bank <= 1'b0;
            swap_pend <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= swap_do;
            if (swap_do) begin
                fill_bank <= ~fill_bank;
                swap_pend <= 1'b0;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= DRAIN_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            dr_q      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (drain_go) begin
                        len_q   <= drain_len;
                        shift_q <= shift_amt;
                        cnt     <= '0;
                        state   <= DRAIN_READ;
                    end
                end
                DRAIN_READ: begin
                    dr_q      <= mem[{~fill_bank, cnt[ADDR_WIDTH-1:0]}];
                    out_valid <= 1'b1;
                    out_last  <= (len_q == 1);
                    state     <= DRAIN_STREAM;
                end
                DRAIN_STREAM: begin
                    if (out_ready) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= DRAIN_IDLE;
                        end else begin
                            // Prefetch the next entry so beats stay back-to-back.
                            dr_q     <= mem[{~fill_bank, cnt_nxt[ADDR_WIDTH-1:0]}];
                            out_last <= (cnt_nxt == len_q - 1'b1);
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= DRAIN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accu_obf_pingpong.sv
// Randomised bench for accu_obf_pingpong against a per-entry integer model
// of both banks, with a scoreboard of expected drained beats.
module tb_accu_obf_pingpong;

    localparam int NB    = 8;
    localparam int PE    = 24;
    localparam int ACC   = 32;
    localparam int OW    = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int SW    = 5;
    localparam int W     = NB * OW;

    logic             clk;
    logic             rst_n;
    logic             acc_valid;
    logic             acc_first;
    logic [AW-1:0]    acc_addr;
    logic [NB*PE-1:0] acc_data;
    logic             swap_req;
    logic             swap_ack;
    logic             drain_start;
    logic [AW:0]      drain_len;
    logic [SW-1:0]    shift_amt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic             drain_busy;
    logic             fill_bank;

    accu_obf_pingpong #(
        .NB_ROWS(NB), .PE_OUT_WIDTH(PE), .ACC_WIDTH(ACC), .OUT_WIDTH(OW),
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_first(acc_first),
        .acc_addr(acc_addr), .acc_data(acc_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .drain_start(drain_start), .drain_len(drain_len), .shift_amt(shift_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .drain_busy(drain_busy), .fill_bank(fill_bank)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_fill   = 0;
    int mdl [0:1][0:DEPTH-1][0:NB-1];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int quant(input int acc, input int sh);
        longint v;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        v = longint'(acc);
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return int'(v);
    endfunction

    function automatic logic [W-1:0] exp_beat(input int bank, input int idx, input int sh);
        logic [W-1:0] b;
        int q;
        b = '0;
        for (int r = 0; r < NB; r++) begin
            q = quant(mdl[bank][idx][r], sh);
            b[r*OW +: OW] = q[OW-1:0];
        end
        return b;
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 32'hFFFFFF)) - 8388608;
        return int'($urandom_range(0, 80000)) - 40000;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic rand_vals(output int v[NB]);
        for (int r = 0; r < NB; r++) v[r] = rnd_val();
    endtask

    task automatic beat(input int addr, input bit first, input int v[NB]);
        logic signed [PE-1:0] t;
        int e;
        acc_valid = 1'b1;
        acc_first = first;
        acc_addr  = AW'(addr);
        for (int r = 0; r < NB; r++) begin
            t = v[r][PE-1:0];
            e = int'(t);
            acc_data[r*PE +: PE] = t;
            mdl[m_fill][addr][r] = first ? e : mdl[m_fill][addr][r] + e;
        end
        tick();
    endtask

    task automatic idle(input int n);
        acc_valid = 1'b0;
        acc_first = 1'b0;
        repeat (n) tick();
    endtask

    task automatic fill_entries(input int n);
        int v[NB];
        for (int i = 0; i < n; i++) begin
            rand_vals(v);
            beat(i, 1'b1, v);
        end
        idle(2);
    endtask

    task automatic wait_swap(input int n_exp, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (swap_ack === 1'b1) seen++;
            tick();
        end
        if (n_exp % 2 == 1) m_fill ^= 1;
        n_checks++;
        if (seen != n_exp) begin
            n_fail++;
            $display("FAIL %s_ack_count: got %0d expected %0d", tag, seen, n_exp);
        end
        n_checks++;
        if (fill_bank !== m_fill[0]) begin
            n_fail++;
            $display("FAIL %s_fill_bank: got %0b expected %0b", tag, fill_bank, m_fill[0]);
        end
    endtask

    task automatic do_swap(input string tag);
        idle(2);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        wait_swap(1, tag);
    endtask

    // Drains the current drain bank; swap_beat >= 0 issues swap_req at that
    // handshake count (0 = together with drain_start) and again two beats later.
    task automatic run_drain(input int len, input int sh, input int mode,
                             input int swap_beat, input bit poke, input string tag);
        int beats;
        int cyc;
        bit stalled;
        bit r1;
        bit r2;
        logic [W-1:0] held;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(exp_beat(m_fill ^ 1, i, sh));
        drain_start = 1'b1;
        drain_len   = (AW+1)'(len);
        shift_amt   = SW'(sh);
        swap_req    = (swap_beat == 0);
        tick();
        drain_start = 1'b0;
        swap_req    = 1'b0;
        r1 = (swap_beat == 0);
        r2 = 1'b0;
        beats = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (beats < len && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            swap_req = 1'b0;
            drain_start = 1'b0;
            if (swap_beat > 0 && !r1 && beats == swap_beat) begin
                swap_req = 1'b1;
                r1 = 1'b1;
            end else if (swap_beat >= 0 && r1 && !r2 && beats == swap_beat + 2) begin
                swap_req = 1'b1;
                r2 = 1'b1;
            end
            if (poke && beats == 1) begin
                drain_start = 1'b1;
                drain_len = (AW+1)'(3);
            end
            if (swap_beat >= 0) begin
                n_checks++;
                if (swap_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_early_swap_ack: got %0b expected 0 at beat %0d", tag, swap_ack, beats);
                end
            end
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: got valid=%0b data=%h expected valid=1 data=%h", tag, out_valid, out_data, held);
                end
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d_data: got %h expected %h", tag, beats, out_data, exp_q[0]);
                end
                n_checks++;
                if (out_last !== (beats == len - 1)) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d_last: got %0b expected %0b", tag, beats, out_last, beats == len - 1);
                end
                if (out_ready) begin
                    got_q.push_back(out_data);
                    void'(exp_q.pop_front());
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        drain_start = 1'b0;
        swap_req = 1'b0;
        n_checks++;
        if (beats != len) begin
            n_fail++;
            $display("FAIL %s_beat_count: got %0d expected %0d within budget", tag, beats, len);
        end
        n_checks++;
        if (out_valid !== 1'b0 || drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_of_drain: got valid=%0b busy=%0b expected 0/0", tag, out_valid, drain_busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) tick();
        m_fill = 0;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b last=%0b ack=%0b expected 0", out_valid, out_last, swap_ack);
        end
        n_checks++;
        if (drain_busy !== 1'b0 || fill_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0b fill_bank=%0b expected 0/0", drain_busy, fill_bank);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        drain_start = 1'b1;
        drain_len = '0;
        shift_amt = '0;
        tick();
        drain_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (drain_busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL len_zero_noop: got busy=%0b valid=%0b expected 0/0", drain_busy, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_overwrite_accumulate();
        int v[NB];
        fill_entries(6);
        rand_vals(v); v[0] = 100;
        beat(5, 1'b1, v);
        idle(1);
        rand_vals(v);
        beat(3, 1'b0, v);
        idle(1);
        rand_vals(v); v[0] = -30;
        beat(5, 1'b0, v);
        do_swap("ovr_swap");
        run_drain(6, 0, 0, -1, 1'b0, "ovr");
        n_checks++;
        if (got_q.size() != 6 || got_q[5][OW-1:0] !== 16'd70) begin
            n_fail++;
            $display("FAIL ovr_acc_lane0: got %0d beats, beat5 lane0=%h expected 6 beats, 0046",
                     got_q.size(), (got_q.size() == 6) ? got_q[5][OW-1:0] : 16'hxxxx);
        end
    endtask

    task automatic test_back_to_back();
        int v[NB];
        fill_entries(4);
        for (int i = 0; i < 24; i++) begin
            rand_vals(v);
            beat(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, v);
        end
        for (int k = 1; k <= 3; k++) begin
            for (int r = 0; r < NB; r++) v[r] = 1000 * k * (r + 1);
            beat(2, k == 1, v);
        end
        do_swap("b2b_swap");
        run_drain(4, 0, 2, -1, 1'b0, "b2b");
        n_checks++;
        if (got_q.size() != 4 || got_q[2][OW-1:0] !== 16'd6000) begin
            n_fail++;
            $display("FAIL b2b_hazard_lane0: got %0d beats, beat2 lane0=%h expected 4 beats, 1770",
                     got_q.size(), (got_q.size() == 4) ? got_q[2][OW-1:0] : 16'hxxxx);
        end
        run_drain(4, int'($urandom_range(1, 12)), 2, -1, 1'b0, "b2b_shift");
    endtask

    task automatic test_quant();
        int v[NB];
        int lane0 [5];
        logic [OW-1:0] want [5];
        int    shv  [5];
        lane0 = '{32'h12345, 1 << 20, -(1 << 20), 383, 384};
        want  = '{16'h0123, 16'h7FFF, 16'h8000, 16'd1, 16'd2};
        shv   = '{8, 0, 0, 8, 8};
        fill_entries(6);
        for (int i = 0; i < 5; i++) begin
            rand_vals(v);
            v[0] = lane0[i];
            beat(i, 1'b1, v);
        end
        do_swap("q_swap");
        for (int pass = 0; pass < 2; pass++) begin
            run_drain(6, (pass == 0) ? 8 : 0, 0, -1, 1'b0, (pass == 0) ? "q_sh8" : "q_sh0");
            for (int i = 0; i < 5; i++) begin
                if (shv[i] == ((pass == 0) ? 8 : 0)) begin
                    n_checks++;
                    if (got_q.size() != 6 || got_q[i][OW-1:0] !== want[i]) begin
                        n_fail++;
                        $display("FAIL quant_entry%0d: got %h expected %h (shift %0d)", i,
                                 (got_q.size() == 6) ? got_q[i][OW-1:0] : 16'hxxxx, want[i], shv[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        fill_entries(4);
        do_swap("bp_swap");
        run_drain(4, int'($urandom_range(0, 12)), 1, -1, 1'b1, "bp");
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_extra_beat: got valid=%0b expected 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_swap_defer();
        fill_entries(8);
        do_swap("sd_swap1");
        run_drain(8, int'($urandom_range(0, 10)), 2, 2, 1'b0, "sd_mid");
        wait_swap(1, "sd_mid_defer");
        fill_entries(8);
        do_swap("sd_swap2");
        run_drain(8, int'($urandom_range(0, 10)), 0, 0, 1'b0, "sd_same");
        wait_swap(1, "sd_same_defer");
    endtask

    task automatic test_reset_mid_drain();
        int beats;
        int cyc;
        fill_entries(8);
        do_swap("rst_swap");
        drain_start = 1'b1;
        drain_len = (AW+1)'(8);
        shift_amt = '0;
        tick();
        drain_start = 1'b0;
        out_ready = 1'b1;
        beats = 0;
        cyc = 0;
        while (beats < 2 && cyc < 50) begin
            swap_req = (cyc == 0);
            if (out_valid === 1'b1) beats++;
            tick();
            cyc++;
        end
        swap_req = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || beats != 2) begin
            n_fail++;
            $display("FAIL rst_pre_valid: got valid=%0b beats=%0d expected 1/2", out_valid, beats);
        end
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        out_ready = 1'b0;
        m_fill = 0;
        n_checks++;
        if (out_valid !== 1'b0 || drain_busy !== 1'b0 || fill_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drain: got valid=%0b busy=%0b fill_bank=%0b expected 0/0/0",
                     out_valid, drain_busy, fill_bank);
        end
        wait_swap(0, "rst_lost_swap");
    endtask

    initial begin
        rst_n = 1'b1;
        acc_valid = 1'b0;
        acc_first = 1'b0;
        acc_addr = '0;
        acc_data = '0;
        swap_req = 1'b0;
        drain_start = 1'b0;
        drain_len = '0;
        shift_amt = '0;
        out_ready = 1'b0;
        test_reset();
        test_len_zero();
        test_overwrite_accumulate();
        test_back_to_back();
        test_quant();
        test_backpressure();
        test_swap_defer();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accu_obf_pingpong.md
Name: accu_obf_pingpong

Overview:
Next-generation accumulating output buffer sitting between the PE array row outputs and the off-array drain path. It holds two banks (ping-pong): the fill bank accumulates partial sums from the array while the drain bank is quantised and streamed out over a valid/ready port. The row count, accumulator width, depth and output width are all parametrised. It adds a runtime accumulate/overwrite mode, read-modify-write (RMW) hazard forwarding, round+saturate quantisation and a drain FSM.

Parameters:
NB_ROWS, 8, PE rows (lanes) handled in parallel
PE_OUT_WIDTH, 24, signed width of each incoming row partial sum
ACC_WIDTH, 32, signed accumulator width per lane per entry; must be >= PE_OUT_WIDTH
OUT_WIDTH, 16, signed width of each drained lane
DEPTH, 1024, entries per bank
ADDR_WIDTH, clogb2(DEPTH), address width
SHIFT_WIDTH, clogb2(ACC_WIDTH), width of the runtime quantisation shift

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high (asserted = 1)
acc_valid  in  1  partial-sum beat present
acc_first  in  1  1 = overwrite entry with sign-extended input; 0 = add to entry
acc_addr  in  ADDR_WIDTH  fill-bank entry address
acc_data  in  NB_ROWS*PE_OUT_WIDTH  packed signed row partial sums; row 0 in the LSBs
swap_req  in  1  one-cycle pulse: exchange fill and drain banks
swap_ack  out  1  one-cycle pulse when the swap takes effect
drain_start  in  1  one-cycle pulse: stream drain bank entries 0..drain_len-1
drain_len  in  ADDR_WIDTH+1  entry count, sampled at drain_start; 0 = no-op
shift_amt  in  SHIFT_WIDTH  arithmetic right shift, sampled at drain_start
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_data  out  NB_ROWS*OUT_WIDTH  quantised lanes, packed like acc_data
out_last  out  1  marks the final beat of a drain
drain_busy  out  1  drain FSM not IDLE
fill_bank  out  1  index of the current fill bank

Behaviour:
- Reset: fill_bank=0; FSM=IDLE; all outputs 0; pending swap cleared; RMW pipeline flushed. Memory contents are not cleared.
- Accumulate pipeline, two stages:
  - Stage 0 (acc_valid cycle): read the fill bank at acc_addr.
  - Stage 1 (next cycle): per lane, new = acc_first ? sext(in) : old + sext(in), wrapping at ACC_WIDTH. Write the result back.
  - Throughput is 1 beat/cycle, with no backpressure on the fill side.
- RMW hazard: if the stage-1 address equals the stage-0 address (back-to-back beats to the same entry), stage 0 uses the stage-1 result by forwarding, not the stale memory value. A double hit to the same address accumulates both beats exactly.
- Swap:
  - swap_req sets a pending flag.
  - The swap executes on the first cycle in which all of these hold: FSM IDLE, RMW pipeline empty, acc_valid=0.
  - On that cycle fill_bank toggles and swap_ack pulses for one cycle.
  - A swap_req arriving while one is already pending merges into it (one swap only).
  - swap_req and drain_start in the same cycle: the drain is accepted first and the swap waits for it to finish.
- Drain FSM: IDLE -> READ -> STREAM -> IDLE.
  - IDLE: drain_start with drain_len>0 latches len and shift, resets the counter to 0, and goes to READ. drain_start with len=0 stays in IDLE. drain_start outside IDLE is ignored.
  - READ: issue a read of the drain bank at the counter; one-cycle memory latency; go to STREAM.
  - STREAM: out_valid=1 with a registered quantised result. On handshake (valid&ready): counter+1. If the counter reached len, go to IDLE with out_valid=0 next cycle; otherwise prefetch the next entry so beats are back-to-back. Full rate is 1 beat/cycle while out_ready=1.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - out_last=1 on the beat where counter==len-1.
- Quantisation per lane:
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at ACC_WIDTH+1 bits so the rounding add cannot overflow.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- The fill and drain banks are always distinct, so fill writes never corrupt a drain in progress.
- Reset mid-operation: the drain aborts, out_valid drops on the next edge, and a pending swap is lost.

Decomposition:
- Shared package: the clogb2 function, drain FSM state enum (IDLE/READ/STREAM), and default width constants.
- Sub-module obf_lane_quant: one lane's combinational round+saturate, parametrised by ACC_WIDTH and OUT_WIDTH and instantiated NB_ROWS times.
- Banks are inferred as simple dual-port arrays inside the top module.

Test Plan:
- Overwrite then accumulate: addr 5, first=1 data lane0=100, then (non-consecutive) first=0 data=-30 -> after swap and drain of len 6 with shift 0, beat 5 lane0 = 70.
- Back-to-back hazard: 3 consecutive beats to addr 2 (first=1 val 1000, then 2000, then 3000) -> drained lane value = 6000 (forwarding verified).
- Quantisation: acc=0x00012345 with shift 8 -> 0x0123. acc=2^20 with shift 0 -> 0x7FFF. acc=-2^20 -> 0x8000. acc=383 with shift 8 -> 1 (round-half-up of 1.496 gives 1); acc=384 with shift 8 -> 2.
- Backpressure: drain len 4 with out_ready toggling 1,0,0,1,... -> exactly 4 beats; out_data stable while stalled; out_last only on beat 3; drain_busy falls after the last handshake.
- Swap deferral: swap_req during an active drain of len 8 -> swap_ack only after the 8th handshake, fill_bank toggles once; a second swap_req while pending yields no extra toggle.
- Reset mid-drain: assert rst_n=1 at beat 2 of 8 -> next cycle out_valid=0, drain_busy=0, fill_bank=0.
